// File: rtl/fetch_stage_pkg.sv
// Shared types and constants for the IF stage.
package fetch_stage_pkg;

  localparam int unsigned XLEN_DEFAULT = 32;
  localparam logic [31:0] NOP_INST     = 32'h0000_0013;
  localparam int unsigned PC_INCREMENT = 4;

  typedef enum logic [1:0] {
    S_IDLE,
    S_FETCH,
    S_HOLD,
    S_DRAIN
  } fetch_state_e;

endpackage

// File: rtl/fetch_skid_buffer.sv
// One-entry holding register for a response that arrives while ID is stalled.
import fetch_stage_pkg::*;

module fetch_skid_buffer #(
  parameter int unsigned XLEN = XLEN_DEFAULT
) (
  input  logic            clk,
  input  logic            rst_n,
  input  logic            load,
  input  logic            drain,
  input  logic            clear,
  input  logic [XLEN-1:0] load_inst,
  input  logic [XLEN-1:0] load_pc,
  output logic [XLEN-1:0] inst,
  output logic [XLEN-1:0] pc,
  output logic            valid
);

  logic [XLEN-1:0] inst_q, inst_d;
  logic [XLEN-1:0] pc_q, pc_d;
  logic            valid_q, valid_d;

  // Clear wins over load, load wins over drain.
  always_comb begin
    inst_d  = inst_q;
    pc_d    = pc_q;
    valid_d = valid_q;
    if (clear) begin
      valid_d = 1'b0;
    end else if (load) begin
      inst_d  = load_inst;
      pc_d    = load_pc;
      valid_d = 1'b1;
    end else if (drain) begin
      valid_d = 1'b0;
    end
  end

  // Entry register.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      inst_q  <= XLEN'(NOP_INST);
      pc_q    <= '0;
      valid_q <= 1'b0;
    end else begin
      inst_q  <= inst_d;
      pc_q    <= pc_d;
      valid_q <= valid_d;
    end
  end

  assign inst  = inst_q;
  assign pc    = pc_q;
  assign valid = valid_q;

endmodule

// File: rtl/fetch_stage.sv
// IF stage: PC generation, imem request handshake and IF/ID register.
// Optional macro FETCH_PERF_CNT_EN adds stall_cycles / flush_count counters.
import fetch_stage_pkg::*;

module fetch_stage #(
  parameter int unsigned     XLEN     = XLEN_DEFAULT,
  parameter logic [XLEN-1:0] RESET_PC = '0
) (
  input  logic            clk,
  input  logic            rst_n,
  input  logic            insert_nop,
  input  logic            redirect_valid,
  input  logic [XLEN-1:0] redirect_pc,
  output logic            imem_req,
  output logic [XLEN-1:0] imem_addr,
  input  logic            imem_ready,
  input  logic [XLEN-1:0] imem_rdata,
  output logic [XLEN-1:0] if_id_inst,
  output logic [XLEN-1:0] if_id_pc,
`ifdef FETCH_PERF_CNT_EN
  output logic [31:0]     stall_cycles,
  output logic [31:0]     flush_count,
`endif
  output logic            if_id_valid
);

  fetch_state_e    state_q, state_d;
  logic [XLEN-1:0] pc_q, pc_d;
  logic [XLEN-1:0] target_q, target_d;
  logic            req_q, req_d;
  logic [XLEN-1:0] inst_q, inst_d;
  logic [XLEN-1:0] ifpc_q, ifpc_d;
  logic            ifv_q, ifv_d;

  logic            skid_load, skid_drain, skid_clear;
  logic [XLEN-1:0] skid_inst, skid_pc;
  logic            skid_valid;
  logic [XLEN-1:0] redirect_tgt;

  assign redirect_tgt = {redirect_pc[XLEN-1:2], 2'b00};

  fetch_skid_buffer #(.XLEN(XLEN)) u_skid (
    .clk       (clk),
    .rst_n     (rst_n),
    .load      (skid_load),
    .drain     (skid_drain),
    .clear     (skid_clear),
    .load_inst (imem_rdata),
    .load_pc   (pc_q),
    .inst      (skid_inst),
    .pc        (skid_pc),
    .valid     (skid_valid)
  );

  // Next state: redirect flushes first, then stall, then normal fetch.
  always_comb begin
    state_d    = state_q;
    pc_d       = pc_q;
    target_d   = target_q;
    inst_d     = inst_q;
    ifpc_d     = ifpc_q;
    ifv_d      = ifv_q;
    skid_load  = 1'b0;
    skid_drain = 1'b0;
    skid_clear = 1'b0;

    if (redirect_valid) begin
      ifv_d      = 1'b0;
      inst_d     = XLEN'(NOP_INST);
      skid_clear = 1'b1;
    end

    case (state_q)
      S_IDLE: begin
        if (redirect_valid) pc_d = redirect_tgt;
        state_d = S_FETCH;
      end
      S_FETCH: begin
        if (redirect_valid) begin
          // A completing response is dropped; an outstanding one must drain.
          if (imem_ready) begin
            pc_d = redirect_tgt;
          end else begin
            target_d = redirect_tgt;
            state_d  = S_DRAIN;
          end
        end else if (imem_ready) begin
          pc_d = pc_q + XLEN'(PC_INCREMENT);
          if (insert_nop) begin
            skid_load = 1'b1;
            state_d   = S_HOLD;
          end else begin
            inst_d = imem_rdata;
            ifpc_d = pc_q;
            ifv_d  = 1'b1;
          end
        end
      end
      S_HOLD: begin
        if (redirect_valid) begin
          pc_d    = redirect_tgt;
          state_d = S_FETCH;
        end else if (!insert_nop) begin
          inst_d     = skid_inst;
          ifpc_d     = skid_pc;
          ifv_d      = skid_valid;
          skid_drain = 1'b1;
          state_d    = S_FETCH;
        end
      end
      S_DRAIN: begin
        // Old request stays on the bus; its response is discarded.
        if (redirect_valid) target_d = redirect_tgt;
        if (imem_ready) begin
          pc_d    = redirect_valid ? redirect_tgt : target_q;
          state_d = S_FETCH;
        end
      end
      default: state_d = S_IDLE;
    endcase

    req_d = (state_d == S_FETCH) || (state_d == S_DRAIN);
  end

  // State, PC and IF/ID registers.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q  <= S_IDLE;
      pc_q     <= RESET_PC;
      target_q <= '0;
      req_q    <= 1'b0;
      inst_q   <= XLEN'(NOP_INST);
      ifpc_q   <= '0;
      ifv_q    <= 1'b0;
    end else begin
      state_q  <= state_d;
      pc_q     <= pc_d;
      target_q <= target_d;
      req_q    <= req_d;
      inst_q   <= inst_d;
      ifpc_q   <= ifpc_d;
      ifv_q    <= ifv_d;
    end
  end

  assign imem_req    = req_q;
  assign imem_addr   = pc_q;
  assign if_id_inst  = inst_q;
  assign if_id_pc    = ifpc_q;
  assign if_id_valid = ifv_q;

`ifdef FETCH_PERF_CNT_EN
  logic [31:0] stall_q, stall_d;
  logic [31:0] flush_q, flush_d;

  // Saturating event counters.
  always_comb begin
    stall_d = stall_q;
    flush_d = flush_q;
    if (insert_nop && (stall_q != 32'hFFFF_FFFF))     stall_d = stall_q + 32'd1;
    if (redirect_valid && (flush_q != 32'hFFFF_FFFF)) flush_d = flush_q + 32'd1;
  end

  // Counter registers.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      stall_q <= '0;
      flush_q <= '0;
    end else begin
      stall_q <= stall_d;
      flush_q <= flush_d;
    end
  end

  assign stall_cycles = stall_q;
  assign flush_count  = flush_q;
`endif

endmodule

// File: tb/tb_fetch_stage.sv
// Bench for fetch_stage: directed vector table, reset/perf sequence, random model check.
module tb_fetch_stage;

  localparam logic [31:0] KEY = 32'hA5A5_A5A5;
  localparam logic [31:0] NOP = 32'h0000_0013;

  logic        clk, rst_n;
  logic        insert_nop, redirect_valid, imem_ready;
  logic [31:0] redirect_pc;
  logic        imem_req, if_id_valid;
  logic [31:0] imem_addr, imem_rdata, if_id_inst, if_id_pc;
  logic        w_req, w_valid;
  logic [31:0] w_addr, w_rdata, w_inst, w_pc;
`ifdef FETCH_PERF_CNT_EN
  logic [31:0] stall_cycles, flush_count, w_stall, w_flush;
`endif

  int n_chk = 0;
  int n_fail = 0;

  assign imem_rdata = imem_addr ^ KEY;
  assign w_rdata    = w_addr ^ KEY;

  fetch_stage dut (
    .clk(clk), .rst_n(rst_n), .insert_nop(insert_nop),
    .redirect_valid(redirect_valid), .redirect_pc(redirect_pc),
    .imem_req(imem_req), .imem_addr(imem_addr), .imem_ready(imem_ready),
    .imem_rdata(imem_rdata), .if_id_inst(if_id_inst), .if_id_pc(if_id_pc),
`ifdef FETCH_PERF_CNT_EN
    .stall_cycles(stall_cycles), .flush_count(flush_count),
`endif
    .if_id_valid(if_id_valid)
  );

  fetch_stage #(.RESET_PC(32'hFFFF_FFF8)) dut_w (
    .clk(clk), .rst_n(rst_n), .insert_nop(insert_nop),
    .redirect_valid(redirect_valid), .redirect_pc(redirect_pc),
    .imem_req(w_req), .imem_addr(w_addr), .imem_ready(imem_ready),
    .imem_rdata(w_rdata), .if_id_inst(w_inst), .if_id_pc(w_pc),
`ifdef FETCH_PERF_CNT_EN
    .stall_cycles(w_stall), .flush_count(w_flush),
`endif
    .if_id_valid(w_valid)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_chk++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %h expected %h", name, act, exp);
    end
  endtask

  typedef struct {
    logic        nop, rd;
    logic [31:0] rpc;
    logic        rdy;
    logic        req;
    logic [31:0] addr;
    logic        v, cp;
    logic [31:0] pc;
    logic        cw;
    logic [31:0] waddr;
  } vec_t;

  function automatic vec_t mk(input logic nop, input logic rd, input logic [31:0] rpc,
                              input logic rdy, input logic req, input logic [31:0] addr,
                              input logic v, input logic cp, input logic [31:0] pc,
                              input logic cw, input logic [31:0] waddr);
    vec_t r;
    r.nop = nop; r.rd = rd; r.rpc = rpc; r.rdy = rdy; r.req = req; r.addr = addr;
    r.v = v; r.cp = cp; r.pc = pc; r.cw = cw; r.waddr = waddr;
    return r;
  endfunction

  vec_t tbl[20];

  // Random-phase model state
  logic [31:0] m_issue, m_deliver, m_drain_addr, tgt;
  logic        m_drain, was_drain, done;
  int          m_stall, m_flush;
  logic        p_req, p_v, p_nop, p_rd, p_rdy;
  logic [31:0] p_addr, p_pc, p_inst, p_rpc;

  initial begin
    //             nop rd rpc           rdy req addr          v  cp pc            cw waddr
    tbl[0]  = mk(0, 0, 32'h0,        1, 1, 32'h0,        0, 1, 32'h0,        1, 32'hFFFF_FFF8);
    tbl[1]  = mk(0, 0, 32'h0,        1, 1, 32'h4,        1, 1, 32'h0,        1, 32'hFFFF_FFFC);
    tbl[2]  = mk(0, 0, 32'h0,        1, 1, 32'h8,        1, 1, 32'h4,        1, 32'h0);
    tbl[3]  = mk(1, 0, 32'h0,        1, 0, 32'hC,        1, 1, 32'h4,        0, 32'h0);
    tbl[4]  = mk(1, 0, 32'h0,        1, 0, 32'hC,        1, 1, 32'h4,        0, 32'h0);
    tbl[5]  = mk(0, 0, 32'h0,        1, 1, 32'hC,        1, 1, 32'h8,        0, 32'h0);
    tbl[6]  = mk(0, 0, 32'h0,        1, 1, 32'h10,       1, 1, 32'hC,        0, 32'h0);
    tbl[7]  = mk(1, 1, 32'h100,      1, 1, 32'h100,      0, 0, 32'h0,        0, 32'h0);
    tbl[8]  = mk(0, 0, 32'h0,        1, 1, 32'h104,      1, 1, 32'h100,      0, 32'h0);
    tbl[9]  = mk(0, 1, 32'h20,       1, 1, 32'h20,       0, 0, 32'h0,        0, 32'h0);
    tbl[10] = mk(0, 0, 32'h0,        0, 1, 32'h20,       0, 0, 32'h0,        0, 32'h0);
    tbl[11] = mk(0, 1, 32'h200,      0, 1, 32'h20,       0, 0, 32'h0,        0, 32'h0);
    tbl[12] = mk(0, 0, 32'h0,        0, 1, 32'h20,       0, 0, 32'h0,        0, 32'h0);
    tbl[13] = mk(0, 0, 32'h0,        1, 1, 32'h200,      0, 0, 32'h0,        0, 32'h0);
    tbl[14] = mk(0, 0, 32'h0,        1, 1, 32'h204,      1, 1, 32'h200,      0, 32'h0);
    tbl[15] = mk(0, 1, 32'h303,      1, 1, 32'h300,      0, 0, 32'h0,        0, 32'h0);
    tbl[16] = mk(0, 0, 32'h0,        1, 1, 32'h304,      1, 1, 32'h300,      0, 32'h0);
    tbl[17] = mk(0, 1, 32'hFFFF_FFFC, 1, 1, 32'hFFFF_FFFC, 0, 0, 32'h0,      0, 32'h0);
    tbl[18] = mk(0, 0, 32'h0,        1, 1, 32'h0,        1, 1, 32'hFFFF_FFFC, 0, 32'h0);
    tbl[19] = mk(0, 0, 32'h0,        1, 1, 32'h4,        1, 1, 32'h0,        0, 32'h0);

    rst_n = 1'b0; insert_nop = 1'b0; redirect_valid = 1'b0; redirect_pc = '0; imem_ready = 1'b0;
    repeat (2) @(negedge clk);
    chk("rst_req",   {31'b0, imem_req}, 32'd0);
    chk("rst_addr",  imem_addr, 32'h0);
    chk("rst_inst",  if_id_inst, NOP);
    chk("rst_pc",    if_id_pc, 32'h0);
    chk("rst_valid", {31'b0, if_id_valid}, 32'd0);
    chk("rst_waddr", w_addr, 32'hFFFF_FFF8);

    // Directed vector table
    rst_n = 1'b1;
    for (int i = 0; i < 20; i++) begin
      insert_nop = tbl[i].nop; redirect_valid = tbl[i].rd;
      redirect_pc = tbl[i].rpc; imem_ready = tbl[i].rdy;
      @(negedge clk);
      chk($sformatf("v%0d_req", i),   {31'b0, imem_req}, {31'b0, tbl[i].req});
      chk($sformatf("v%0d_addr", i),  imem_addr, tbl[i].addr);
      chk($sformatf("v%0d_valid", i), {31'b0, if_id_valid}, {31'b0, tbl[i].v});
      chk($sformatf("v%0d_inst", i),  if_id_inst, tbl[i].v ? (tbl[i].pc ^ KEY) : NOP);
      if (tbl[i].cp) chk($sformatf("v%0d_pc", i), if_id_pc, tbl[i].pc);
      if (tbl[i].cw) begin
        chk($sformatf("v%0d_wreq", i),  {31'b0, w_req}, 32'd1);
        chk($sformatf("v%0d_waddr", i), w_addr, tbl[i].waddr);
      end
    end

    // Stalls and a redirect while waiting, then reset mid-transaction
    rst_n = 1'b0; insert_nop = 1'b0; redirect_valid = 1'b0; imem_ready = 1'b0;
    @(negedge clk);
    rst_n = 1'b1; insert_nop = 1'b1;
    repeat (3) @(negedge clk);
    insert_nop = 1'b0; redirect_valid = 1'b1; redirect_pc = 32'h40;
    @(negedge clk);
    redirect_valid = 1'b0;
    @(negedge clk);
    chk("wait_req",   {31'b0, imem_req}, 32'd1);
    chk("wait_addr",  imem_addr, 32'h0);
    chk("wait_valid", {31'b0, if_id_valid}, 32'd0);
`ifdef FETCH_PERF_CNT_EN
    chk("perf_stall", stall_cycles, 32'd3);
    chk("perf_flush", flush_count, 32'd1);
`endif
    #3 rst_n = 1'b0;
    #1;
    chk("mrst_req",   {31'b0, imem_req}, 32'd0);
    chk("mrst_addr",  imem_addr, 32'h0);
    chk("mrst_inst",  if_id_inst, NOP);
    chk("mrst_pc",    if_id_pc, 32'h0);
    chk("mrst_valid", {31'b0, if_id_valid}, 32'd0);
`ifdef FETCH_PERF_CNT_EN
    chk("mrst_stall", stall_cycles, 32'd0);
    chk("mrst_flush", flush_count, 32'd0);
`endif

    // Random traffic against a transaction-level model
    @(negedge clk);
    rst_n = 1'b1;
    m_issue = 32'h0; m_deliver = 32'h0; m_drain = 1'b0; m_drain_addr = '0;
    m_stall = 0; m_flush = 0;
    for (int cyc = 0; cyc < 3000; cyc++) begin
      insert_nop     = (cyc != 0) && ($urandom_range(3) == 0);
      redirect_valid = ($urandom_range(15) == 0);
      redirect_pc    = $urandom;
      imem_ready     = ($urandom_range(2) != 0);
      p_req = imem_req; p_addr = imem_addr; p_v = if_id_valid; p_pc = if_id_pc;
      p_inst = if_id_inst; p_nop = insert_nop; p_rd = redirect_valid;
      p_rpc = redirect_pc; p_rdy = imem_ready;
      @(negedge clk);
      was_drain = m_drain;
      done = p_req && p_rdy;

      if (p_req && !p_rdy) begin
        chk("r_req_held",  {31'b0, imem_req}, 32'd1);
        chk("r_addr_held", imem_addr, p_addr);
      end
      if (!p_req && (!p_nop || p_rd)) chk("r_req_resume", {31'b0, imem_req}, 32'd1);
      if (done && p_nop && !p_rd && !was_drain) chk("r_req_hold", {31'b0, imem_req}, 32'd0);

      if (done) begin
        chk("r_done_addr", p_addr, was_drain ? m_drain_addr : m_issue);
        if (was_drain) m_drain = 1'b0;
        else if (!p_rd) m_issue = m_issue + 32'd4;
      end
      if (p_rd) begin
        tgt = p_rpc & 32'hFFFF_FFFC;
        m_issue = tgt; m_deliver = tgt;
        if (p_req && !p_rdy && !was_drain) begin
          m_drain = 1'b1; m_drain_addr = p_addr;
        end
      end

      if (p_rd) begin
        chk("r_flush_valid", {31'b0, if_id_valid}, 32'd0);
        chk("r_flush_inst",  if_id_inst, NOP);
      end else if (p_nop) begin
        chk("r_stall_valid", {31'b0, if_id_valid}, {31'b0, p_v});
        chk("r_stall_pc",    if_id_pc, p_pc);
        chk("r_stall_inst",  if_id_inst, p_inst);
      end else if (done && !was_drain) begin
        chk("r_load_valid", {31'b0, if_id_valid}, 32'd1);
        chk("r_load_pc",    if_id_pc, p_addr);
      end

      if (if_id_valid && (!p_v || if_id_pc != p_pc)) begin
        chk("r_order_pc",   if_id_pc, m_deliver);
        chk("r_order_inst", if_id_inst, if_id_pc ^ KEY);
        m_deliver = m_deliver + 32'd4;
      end
      m_stall += int'(p_nop);
      m_flush += int'(p_rd);
    end
`ifdef FETCH_PERF_CNT_EN
    chk("r_perf_stall", stall_cycles, 32'(m_stall));
    chk("r_perf_flush", flush_count, 32'(m_flush));
`endif

    $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
    $finish;
  end

endmodule

// File: doc/fetch_stage.md
Name: fetch_stage

Overview:
- IF-stage PC generator plus IF/ID pipeline register for the RISC-V core.
- Issues instruction-memory requests, latches the returned instruction and PC into the IF/ID register, and feeds the ID stage.
- Consumes insert_nop from hazard_detection to stall, and a redirect from EX (branch/jump) to flush.

Parameters:
- RESET_PC, 32'h0000_0000, first fetch address after reset.
- XLEN, 32, PC and instruction width.

Ports:
- clk  input  1  core clock.
- rst_n  input  1  asynchronous active-low reset.
- insert_nop  input  1  load-use stall from hazard_detection.
- redirect_valid  input  1  taken branch/jump from EX.
- redirect_pc  input  XLEN  redirect target.
- imem_req  output  1  fetch request valid.
- imem_addr  output  XLEN  fetch address.
- imem_ready  input  1  response valid this cycle.
- imem_rdata  input  XLEN  instruction word.
- if_id_inst  output  XLEN  instruction to ID.
- if_id_pc  output  XLEN  PC of if_id_inst.
- if_id_valid  output  1  IF/ID holds a real instruction.

Behaviour:
- Reset values (async, rst_n low):
  - pc=RESET_PC, state=S_IDLE, imem_req=0.
  - if_id_inst=32'h0000_0013 (NOP_INST), if_id_pc=0, if_id_valid=0.
  - Skid buffer empty.
- Memory protocol:
  - imem_req/imem_addr are held stable until the cycle where imem_ready=1 (transaction completes on that edge).
  - Zero-wait memory completes the same cycle; minimum latency from request to IF/ID is 1 edge.
- States:
  - S_IDLE: one cycle after reset release, imem_req=0 -> S_FETCH.
  - S_FETCH: imem_req=1, imem_addr=pc.
    - On ready with no stall/redirect: load IF/ID {rdata, pc, valid=1}, pc<=pc+4, stay.
    - On ready during insert_nop: write the response into the skid buffer, pc<=pc+4 -> S_HOLD.
    - On ready with the skid buffer already full (stall asserted in S_HOLD): does not occur; no request is issued while in S_HOLD.
  - S_HOLD: imem_req=0, IF/ID and pc frozen. When insert_nop falls, skid -> IF/ID, skid empties -> S_FETCH.
  - S_DRAIN: entered on redirect while a request is outstanding and not completing. imem_req stays 1 with the old address; the response is discarded on ready, then pc<=redirect target (latched) -> S_FETCH.
- Stall (insert_nop=1, no redirect):
  - pc, if_id_* and if_id_valid hold.
  - A fetch completing this cycle goes to the skid buffer, never to IF/ID.
- Redirect (redirect_valid=1):
  - Highest priority over insert_nop.
  - Next edge: if_id_valid<=0, if_id_inst<=NOP_INST, skid cleared.
  - pc<=redirect_pc if no request is pending or the pending one completes this cycle (its data is dropped); otherwise go to S_DRAIN holding the target.
  - A redirect during S_DRAIN replaces the latched target.
- Arithmetic: pc+4 is modulo 2^XLEN; 32'hFFFF_FFFC wraps to 0. redirect_pc[1:0] is forced to 0.
- Reset mid-transaction abandons the transaction; the memory must tolerate imem_req dropping.

Optional Feature:
- Macro: FETCH_PERF_CNT_EN.
- Defined: adds outputs stall_cycles[31:0] and flush_count[31:0]. Both reset to 0, saturate at 32'hFFFF_FFFF.
  - stall_cycles increments each cycle insert_nop=1.
  - flush_count increments each cycle redirect_valid=1.
- Undefined: ports and logic are absent; behaviour is otherwise identical.

Decomposition:
- package_project_typedefs gains:
  - FetchState enum {S_IDLE, S_FETCH, S_HOLD, S_DRAIN}.
  - NOP_INST = 32'h0000_0013.
  - PC_INCREMENT = 4.
- One sub-module: fetch_skid_buffer, a 1-entry {inst, pc, valid} register with load/drain/clear inputs.

Test Plan:
- Reset, then imem_ready tied 1 with rdata=addr^32'hA5A5_A5A5 -> addresses 0,4,8 issued; if_id_pc=0 with if_id_valid=1 one edge after S_FETCH entry.
- Sequential fetch, then insert_nop=1 for 2 cycles at pc=8 -> IF/ID holds pc=4; pc=8 response lands in the skid buffer; after release if_id_pc=8, next fetch addr=12, nothing lost or duplicated.
- redirect_valid=1, redirect_pc=32'h100 with insert_nop=1 in the same cycle -> if_id_valid=0 and if_id_inst=32'h13 next edge; next imem_addr=32'h100.
- imem_ready held 0 for 3 cycles at addr=0x20, redirect to 0x200 on the 2nd cycle -> imem_addr stays 0x20 until ready; that response is dropped; next request addr=0x200.
- Start at RESET_PC=32'hFFFF_FFF8 -> addresses FFFF_FFF8, FFFF_FFFC, 0000_0000.
- rst_n pulsed low mid-wait -> all outputs at reset values immediately; with FETCH_PERF_CNT_EN, 3 stall cycles and 1 redirect give stall_cycles=3 and flush_count=1 before the reset.
